// File: rtl/qfas_pkg.sv
// Shared constants for the registered add/subtract leaf cell.
package qfas_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/quad_full_add_sub_if.sv
// Operand/result bundle for quad_full_add_sub; master drives operands, slave returns the registered result.
interface quad_full_add_sub_if import qfas_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             ci;
  logic [WIDTH-1:0] y;
  logic             co;

  modport master (
    output a, b, sel, ci,
    input  y, co
  );

  modport slave (
    input  a, b, sel, ci,
    output y, co
  );

endinterface

// File: rtl/quad_full_add_sub_full_adder.sv
// One-bit full adder cell; the ripple chain in quad_full_add_sub is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/quad_full_add_sub.sv
// Registered WIDTH-bit adder/subtractor: ripple of full adders feeding a one-cycle output register.
module quad_full_add_sub import qfas_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  quad_full_add_sub_if.slave   bus
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] y_reg;
  logic             co_reg;
  logic             is_sub;

  // Subtract is A + ~B + ~CI; CO stays the raw chain carry (1 = no borrow).
  assign is_sub = (bus.sel == OP_SUB);
  assign bx     = bus.b ^ {WIDTH{is_sub}};
  assign c[0]   = bus.ci ^ is_sub;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
      full_adder u_fa (
        .a    (bus.a[gi]),
        .b    (bx[gi]),
        .cin  (c[gi]),
        .s    (sum[gi]),
        .cout (c[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg  <= '0;
      co_reg <= 1'b0;
    end else begin
      y_reg  <= sum;
      co_reg <= c[WIDTH];
    end
  end

  assign bus.y  = y_reg;
  assign bus.co = co_reg;

endmodule

// File: tb/tb_quad_full_add_sub.sv
// Scoreboard bench for quad_full_add_sub: driver queues expected results, monitor checks one cycle later.
module tb_quad_full_add_sub;

  logic clk = 1'b0;
  logic rst;

  quad_full_add_sub_if #(.WIDTH(4)) bus ();

  quad_full_add_sub #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] exp;
    bit         verbose;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   draining_done = 1'b0;

  // Arithmetic view of the operation: plain sum for add, difference with a no-borrow flag for subtract.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic s, input logic ci);
    int ai, bi, cii, d;
    ai  = int'(a);
    bi  = int'(b);
    cii = int'(ci);
    if (!s) begin
      d = ai + bi + cii;
      return 5'(d);
    end
    d = ai - bi - cii;
    return {(d >= 0), 4'(d)};
  endfunction

  // Inputs change 2 time units after the edge; the monitor samples 1 unit after it.
  task automatic drive(input string nm, input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic s, input logic ci, input logic [4:0] exp, input bit verbose);
    exp_t e;
    @(posedge clk);
    #2;
    rst     = r;
    bus.a   = a;
    bus.b   = b;
    bus.sel = s;
    bus.ci  = ci;
    e.name    = nm;
    e.exp     = exp;
    e.verbose = verbose;
    q.push_back(e);
  endtask

  // Monitor: every edge produces exactly one result, so pop one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if ({bus.co, bus.y} !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got co,y=%b_%b required %b_%b", e.name, bus.co, bus.y, e.exp[4], e.exp[3:0]);
        end else if (e.verbose) begin
          $display("ok   %s: co,y=%b_%b", e.name, bus.co, bus.y);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ra, rb;
    logic       rs, rc, rr;
    rst     = 1'b1;
    bus.a   = 4'hF;
    bus.b   = 4'hF;
    bus.sel = 1'b0;
    bus.ci  = 1'b1;

    // Reset holds outputs at zero regardless of inputs, then first real result.
    drive("reset0", 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 5'b0_0000, 1'b1);
    drive("reset1", 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b1, 5'b0_0000, 1'b1);
    drive("post_reset", 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 5'b1_1111, 1'b1);

    drive("add_3_3",   1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0, 5'b0_0110, 1'b1);
    drive("add_5_10",  1'b0, 4'b0101, 4'b1010, 1'b0, 1'b0, 5'b0_1111, 1'b1);
    drive("add_4_3",   1'b0, 4'b0100, 4'b0011, 1'b0, 1'b0, 5'b0_0111, 1'b1);
    drive("add_10_11", 1'b0, 4'b1010, 4'b1011, 1'b0, 1'b0, 5'b1_0101, 1'b1);

    drive("sub_3_3",   1'b0, 4'b0011, 4'b0011, 1'b1, 1'b0, 5'b1_0000, 1'b1);
    drive("sub_5_10",  1'b0, 4'b0101, 4'b1010, 1'b1, 1'b0, 5'b0_1011, 1'b1);
    drive("sub_4_3",   1'b0, 4'b0100, 4'b0011, 1'b1, 1'b0, 5'b1_0001, 1'b1);
    drive("sub_10_11", 1'b0, 4'b1010, 4'b1011, 1'b1, 1'b0, 5'b0_1111, 1'b1);

    drive("add_ci_15_0", 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 5'b1_0000, 1'b1);
    drive("sub_bi_4_3",  1'b0, 4'b0100, 4'b0011, 1'b1, 1'b1, 5'b1_0000, 1'b1);
    drive("sub_bi_0_0",  1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'b0_1111, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        drive($sformatf("toggle%0d_add", i), 1'b0, 4'b0110, 4'b0010, 1'b0, 1'b0, 5'b0_1000, 1'b1);
      else
        drive($sformatf("toggle%0d_sub", i), 1'b0, 4'b0110, 4'b0010, 1'b1, 1'b0, 5'b1_0100, 1'b1);
    end

    drive("mid_pre",    1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0, 5'b0_0110, 1'b1);
    drive("mid_rst",    1'b1, 4'b0101, 4'b1010, 1'b0, 1'b0, 5'b0_0000, 1'b1);
    drive("mid_resume", 1'b0, 4'b0100, 4'b0011, 1'b0, 1'b0, 5'b0_0111, 1'b1);
    drive("mid_sub",    1'b0, 4'b1010, 4'b1011, 1'b1, 1'b0, 5'b0_1111, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 99) == 0);
      drive($sformatf("rand%0d", i), rr, ra, rb, rs, rc,
            rr ? 5'b0_0000 : model(ra, rb, rs, rc), 1'b0);
    end

    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending results required 0", q.size());
    end
    draining_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quad_full_add_sub.md
# quad_full_add_sub

Registered 4-bit adder/subtractor (the `qfas` block). It selects between A + B + CI and A − B − borrow-in, built from a ripple chain of one-bit full adders. The result and carry-out are captured in an output register on every clock. It serves as the arithmetic leaf cell for datapaths that need a shared add/sub unit with carry chaining between slices.

## Interface
- WIDTH, default 4: operand and result width; chain length of full-adder cells. All test values below use WIDTH = 4.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- A  in  WIDTH  first operand, unsigned or two's complement.
- B  in  WIDTH  second operand.
- SEL  in  1  operation select: 0 = add, 1 = subtract.
- CI  in  1  carry-in when adding; borrow-in when subtracting.
- Y  out  WIDTH  registered result.
- CO  out  1  registered carry-out; when subtracting, 1 = no borrow.

## Operation
- Effective operand: Bx = B XOR {WIDTH{SEL}}.
- Effective LSB carry-in: c0 = CI XOR SEL.
- Add (SEL = 0): {CO, Y} = A + B + CI.
- Subtract (SEL = 1): {CO, Y} = A + ~B + ~CI, which equals A − B − CI modulo 2^WIDTH.
- Carry-out for subtract is the raw chain carry, not inverted.
- Each bit i is a full adder:
  - Y[i] = A[i] ^ Bx[i] ^ c[i]
  - c[i+1] = A[i]&Bx[i] | c[i]&(A[i]^Bx[i])
  - CO = c[WIDTH]
- Result is WIDTH+1 bits and always wraps modulo 2^(WIDTH+1). No saturation, no overflow flag.
- Inputs need no qualifier. Every cycle is a valid operation.

## Timing
- Combinational ripple from A/B/SEL/CI to the D inputs of the output register.
- Latency is exactly 1 cycle: inputs present before rising edge N appear on Y/CO after edge N.
- Throughput is one operation per cycle. A new SEL is honoured on the very next edge with no bubble.
- Reset:
  - rst = 1 at a rising edge forces Y = 0 and CO = 0 on that edge, regardless of the inputs.
  - rst takes priority over any computation in flight.
  - The first post-reset result appears on the first edge where rst = 0.
- Outputs hold their value between edges. Before the first reset, outputs are undefined; the bench must reset first.
- The ripple path has no multicycle exceptions. The critical path is WIDTH full-adder carry stages.

## Structure
- Sub-module `full_adder`: inputs a, b, cin; outputs s, cout; purely combinational. The top level instantiates WIDTH copies in a generate loop.
- Top level contains the B/SEL XOR stage, the carry-in XOR, the carry vector c[WIDTH:0], and the output register with synchronous reset.
- Shared package `qfas_pkg`:
  - OP_ADD = 1'b0 and OP_SUB = 1'b1 constants.
  - Default WIDTH localparam.

## Test plan
- Reset: assert rst for 2 cycles with A = 1111, B = 1111, SEL = 0, CI = 1 -> Y = 0000 and CO = 0. After release, the next edge gives CO,Y = 1_1111.
- Add, SEL = 0, CI = 0, one vector per cycle, each checked 1 cycle later:
  - 0011 + 0011 -> 0_0110
  - 0101 + 1010 -> 0_1111
  - 0100 + 0011 -> 0_0111
  - 1010 + 1011 -> 1_0101
- Subtract, SEL = 1, CI = 0, each checked 1 cycle later:
  - 0011 − 0011 -> 1_0000
  - 0101 − 1010 -> 0_1011
  - 0100 − 0011 -> 1_0001
  - 1010 − 1011 -> 0_1111
- Carry/borrow-in:
  - SEL = 0, CI = 1, A = 1111, B = 0000 -> 1_0000
  - SEL = 1, CI = 1, A = 0100, B = 0011 -> 1_0000 (4 − 3 − 1)
  - SEL = 1, CI = 1, A = 0000, B = 0000 -> 0_1111
- Back-to-back SEL toggling every cycle with A = 0110, B = 0010: outputs alternate 0_1000 / 1_0100 with no stall.
- Mid-stream reset: assert rst for one cycle during a sequence -> that cycle's output is 0_0000, and the following cycle resumes correct results.
- Randomized 10k vectors against the reference model {CO, Y} = SEL ? A + ~B + ~CI : A + B + CI, checked with 1-cycle latency.
